// File: rtl/uart_tx_feeder.sv
// Programs a Wishbone UART (DLAB, DL1, DL2, LCR) then streams bytes into its THR, polling LSR.THRE once per BURST.
// Each access: one idle cycle, then cyc/stb held until ack; ready_o is high only while IDLE after configuration.
module uart_tx_feeder #(
    parameter logic [7:0]  LCR_VAL = 8'h1B,
    parameter logic [15:0] DIVISOR = 16'd3,
    parameter int          BURST   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        init_done_o,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {
        CFG_LCR_DLAB,
        CFG_DL1,
        CFG_DL2,
        CFG_LCR,
        IDLE,
        POLL_LSR,
        WR_THR
    } state_t;

    localparam logic [4:0] BURST_CREDIT = 5'(BURST);

    state_t      state, state_nxt;
    logic        wait_ack, wait_ack_nxt;
    logic [4:0]  credit, credit_nxt;
    logic [7:0]  hold, hold_nxt;
    logic        init_done_nxt;

    logic [4:0]  acc_adr;
    logic [7:0]  acc_byte;
    logic        acc_we;

    // Only LSR.THRE is consumed from the read bus.
    logic unused_dat;
    assign unused_dat = ^{wb_dat_i[31:14], wb_dat_i[12:0]};

    always_comb begin
        acc_adr  = 5'd0;
        acc_byte = 8'h00;
        acc_we   = 1'b1;
        case (state)
            CFG_LCR_DLAB: begin acc_adr = 5'd3; acc_byte = LCR_VAL | 8'h80; end
            CFG_DL1:      begin acc_adr = 5'd0; acc_byte = DIVISOR[7:0];    end
            CFG_DL2:      begin acc_adr = 5'd1; acc_byte = DIVISOR[15:8];   end
            CFG_LCR:      begin acc_adr = 5'd3; acc_byte = LCR_VAL & 8'h7F; end
            POLL_LSR:     begin acc_adr = 5'd5; acc_we = 1'b0;              end
            WR_THR:       begin acc_adr = 5'd0; acc_byte = hold;            end
            default:      acc_we = 1'b0;
        endcase
    end

    // Bus is driven only during the wait-ack phase, so the issue phase doubles as the idle gap.
    assign wb_cyc_o = wait_ack;
    assign wb_stb_o = wait_ack;
    assign wb_we_o  = wait_ack & acc_we;
    assign wb_adr_o = wait_ack ? acc_adr : 5'd0;
    assign wb_sel_o = wait_ack ? (4'b0001 << acc_adr[1:0]) : 4'b0000;
    assign wb_dat_o = (wait_ack && acc_we) ? ({24'b0, acc_byte} << {acc_adr[1:0], 3'b000}) : 32'h0;
    assign ready_o  = (state == IDLE) && init_done_o;

    always_comb begin
        state_nxt     = state;
        wait_ack_nxt  = wait_ack;
        credit_nxt    = credit;
        hold_nxt      = hold;
        init_done_nxt = init_done_o;
        if (state == IDLE) begin
            if (valid_i && ready_o) begin
                hold_nxt  = byte_i;
                state_nxt = (credit != 5'd0) ? WR_THR : POLL_LSR;
            end
        end else if (!wait_ack) begin
            wait_ack_nxt = 1'b1;
        end else if (wb_ack_i) begin
            wait_ack_nxt = 1'b0;
            case (state)
                CFG_LCR_DLAB: state_nxt = CFG_DL1;
                CFG_DL1:      state_nxt = CFG_DL2;
                CFG_DL2:      state_nxt = CFG_LCR;
                CFG_LCR: begin
                    state_nxt     = IDLE;
                    init_done_nxt = 1'b1;
                end
                POLL_LSR: begin
                    if (wb_dat_i[13]) begin
                        credit_nxt = BURST_CREDIT;
                        state_nxt  = WR_THR;
                    end
                end
                WR_THR: begin
                    credit_nxt = (credit == 5'd0) ? 5'd0 : credit - 5'd1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= CFG_LCR_DLAB;
            wait_ack    <= 1'b0;
            credit      <= 5'd0;
            hold        <= 8'h00;
            init_done_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_ack    <= wait_ack_nxt;
            credit      <= credit_nxt;
            hold        <= hold_nxt;
            init_done_o <= init_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: Wishbone slave model with programmable ack delay and LSR responses,
// plus a transaction-level expectation queue built from the configuration and credit rules.
module tb_uart_tx_feeder;

    localparam int BURST = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [7:0]  byte_i   = 8'h00;
    logic        valid_i  = 1'b0;
    logic        ready_o;
    logic        init_done_o;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;

    uart_tx_feeder #(.LCR_VAL(8'h1B), .DIVISOR(16'd3), .BURST(BURST)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .byte_i(byte_i), .valid_i(valid_i),
        .ready_o(ready_o), .init_done_o(init_done_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s timed out", tag);
    endtask

    // Packed access record: {we, sel, adr, dat}.
    function automatic logic [41:0] tx(input logic we, input logic [3:0] sel,
                                       input logic [4:0] adr, input logic [31:0] dat);
        return {we, sel, adr, dat};
    endfunction

    // ---------------- Wishbone slave model ----------------
    int          ack_delay = 1;
    int          wcnt      = 0;
    int          held      = 0;
    int          aborts    = 0;
    bit          in_acc    = 0;
    bit          acked     = 0;
    bit          thre;
    bit          lsr_q[$];
    logic [41:0] log_q[$];
    logic [42:0] snap;
    logic [42:0] cur;
    assign cur = {wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o};

    always @(negedge wb_clk_i) begin
        if (wb_cyc_o === 1'b1) begin
            if (!in_acc) begin
                in_acc = 1;
                acked  = 0;
                snap   = cur;
                wcnt   = 0;
            end else begin
                check("hold", cur, snap);
                check("cyc_drop", acked, 0);
            end
            if (!acked) begin
                if (wcnt >= ack_delay) begin
                    acked    = 1;
                    held     = wcnt;
                    wb_ack_i = 1'b1;
                    thre     = 1;
                    if (wb_adr_o == 5'd5 && lsr_q.size() > 0) thre = lsr_q.pop_front();
                    wb_dat_i = ($urandom & ~32'h2000) | (32'(thre) << 13);
                end else begin
                    wcnt++;
                end
            end
        end else begin
            wb_ack_i = 1'b0;
            wb_dat_i = 32'h0;
            if (in_acc) begin
                if (acked) log_q.push_back(snap[41:0]);
                else aborts++;
                in_acc = 0;
            end
        end
    end

    // ---------------- Reference model and helpers ----------------
    int          mcredit = 0;
    logic [41:0] exp_q[$];
    logic [7:0]  bytes_q[$];

    task automatic next_log(output logic [41:0] v);
        if (log_q.size() > 0) v = log_q.pop_front();
        else v = '1;
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        for (int n = 0; n < 3000 && quiet < 3; n++) begin
            @(negedge wb_clk_i);
            if (ready_o === 1'b1 && wb_cyc_o === 1'b0 && !in_acc) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) timeout(tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        valid_i = 1'b1;
        byte_i  = b;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (ready_o === 1'b1) begin
                @(posedge wb_clk_i);
                #1 valid_i = 1'b0;
                done = 1;
            end
            @(negedge wb_clk_i);
        end
        valid_i = 1'b0;
        if (!done) timeout("send_byte");
    endtask

    task automatic expect_config(input string tag);
        logic [41:0] v;
        next_log(v); check({tag, "_lcr_dlab"}, v, tx(1, 4'h8, 5'd3, 32'h9B000000));
        next_log(v); check({tag, "_dl1"},      v, tx(1, 4'h1, 5'd0, 32'h00000003));
        next_log(v); check({tag, "_dl2"},      v, tx(1, 4'h2, 5'd1, 32'h00000000));
        next_log(v); check({tag, "_lcr"},      v, tx(1, 4'h8, 5'd3, 32'h1B000000));
        check({tag, "_init_done"}, init_done_o, 1'b1);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_extra"}, log_q.size(), 0);
    endtask

    // n random bytes; a poll sees between zmin and zmax THRE=0 replies before THRE=1.
    task automatic run_batch(input string tag, input int n, input int zmin, input int zmax);
        logic [41:0] v;
        int          z;
        logic [7:0]  b;
        exp_q.delete();
        bytes_q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (mcredit == 0) begin
                z = int'($urandom_range(zmax, zmin));
                for (int k = 0; k < z; k++) lsr_q.push_back(1'b0);
                lsr_q.push_back(1'b1);
                for (int k = 0; k <= z; k++) exp_q.push_back(tx(0, 4'h2, 5'd5, 32'h0));
                mcredit = BURST;
            end
            exp_q.push_back(tx(1, 4'h1, 5'd0, {24'h0, b}));
            mcredit--;
            bytes_q.push_back(b);
        end
        foreach (bytes_q[i]) send_byte(bytes_q[i]);
        wait_quiet({tag, "_quiet"});
        check({tag, "_count"}, log_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            next_log(v);
            check($sformatf("%s_tx%0d", tag, i), v, exp_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus"}, {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, '0);
        check({tag, "_ready"}, ready_o, 1'b0);
        check({tag, "_init"}, init_done_o, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1 check_reset_outputs("reset_pulse");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        mcredit  = 0;
        lsr_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence ----------------
    initial begin
        logic [41:0] v;
        bit          seen;

        repeat (3) @(posedge wb_clk_i);
        #1 check_reset_outputs("reset");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wait_quiet("cfg_quiet");
        expect_config("cfg");

        // Single byte with immediate THRE=1: one LSR read then the THR write.
        lsr_q.push_back(1'b1);
        send_byte(8'h5A);
        wait_quiet("b5a_quiet");
        check("b5a_count", log_q.size(), 2);
        next_log(v); check("b5a_lsr", v, tx(0, 4'h2, 5'd5, 32'h0));
        next_log(v); check("b5a_thr", v, tx(1, 4'h1, 5'd0, 32'h0000005A));
        mcredit = BURST - 1;

        // Remaining credit spent without polling, under random ack delays.
        ack_delay = int'($urandom_range(3, 1));
        run_batch("drain", BURST - 1, 0, 0);

        // THRE=0 twice: three polls then the write.
        ack_delay = 1;
        run_batch("thre0", 1, 2, 2);

        // After reset, 17 back-to-back bytes: polls only before bytes 1 and 17.
        do_reset();
        ack_delay = int'($urandom_range(3, 1));
        wait_quiet("cfg2_quiet");
        expect_config("cfg2");
        ack_delay = 1;
        run_batch("b17", 17, 0, 0);

        // Slow ack: every field held while waiting, one access completes.
        ack_delay = 5;
        held = 0;
        run_batch("slow", 1, 0, 0);
        check("slow_held", held, 5);

        // Reset while a THR write is stalled waiting for ack.
        ack_delay = 50;
        aborts = 0;
        send_byte(8'hC3);
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge wb_clk_i);
            if (wb_cyc_o === 1'b1 && wb_we_o === 1'b1 && wb_adr_o === 5'd0) seen = 1;
        end
        if (!seen) timeout("thr_stall");
        check("stall_dat", wb_dat_o, 32'h000000C3);
        repeat (3) @(negedge wb_clk_i);
        check("stall_cyc", wb_cyc_o, 1'b1);
        do_reset();
        ack_delay = 1;
        wait_quiet("cfg3_quiet");
        check("abort_count", aborts, 1);
        expect_config("cfg3");

        // Random traffic with random THRE=0 runs and ack delays.
        ack_delay = int'($urandom_range(2, 1));
        run_batch("rand", 20, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter LCR_VAL, default 8'h1B, is the line-control byte written after divisor programming.
REQ-002 Parameter DIVISOR, default 16'd3, is the baud divisor; the low byte goes to DL1 and the high byte to DL2.
REQ-003 Parameter BURST, default 16, is the bytes written per observed THRE=1 (UART TX FIFO depth).
REQ-004 wb_clk_i  in  1  clock; the only clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 byte_i  in  8  transmit byte from upstream.
REQ-007 valid_i  in  1  byte_i valid.
REQ-008 ready_o  out  1  feeder accepts byte_i this cycle.
REQ-009 init_done_o  out  1  UART configuration complete.
REQ-010 wb_adr_o  out  5  Wishbone byte address to uart_top.
REQ-011 wb_dat_o  out  32  Wishbone write data.
REQ-012 wb_dat_i  in  32  Wishbone read data.
REQ-013 wb_sel_o  out  4  byte-lane select.
REQ-014 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone write enable, strobe, cycle.
REQ-015 wb_ack_i  in  1  Wishbone acknowledge.

Function
REQ-016 Lane rule for every access: wb_sel_o = 1 << wb_adr_o[1:0]; the write byte sits on lane wb_adr_o[1:0]; all other wb_dat_o bits are 0.
REQ-017 Bus cycle: cyc, stb, adr, sel, we and dat are driven together and held unchanged until the first cycle with wb_ack_i=1.
REQ-018 On the clock edge that samples ack, cyc and stb are cleared; at least one idle cycle (cyc=0) separates consecutive accesses.
REQ-019 When idle: cyc=stb=we=0, adr=0, sel=0, dat=0; no X is ever driven.
REQ-020 FSM states: CFG_LCR_DLAB, CFG_DL1, CFG_DL2, CFG_LCR, IDLE, POLL_LSR, WR_THR; each access state has an issue and a wait-ack phase.
REQ-021 CFG_LCR_DLAB writes adr 3, data LCR_VAL|8'h80.
REQ-022 CFG_DL1 writes adr 0, data DIVISOR[7:0].
REQ-023 CFG_DL2 writes adr 1, data DIVISOR[15:8].
REQ-024 CFG_LCR writes adr 3, data LCR_VAL & 8'h7F.
REQ-025 After CFG_LCR is acked, init_done_o rises and stays 1 until reset; the FSM enters IDLE.
REQ-026 ready_o=1 only in IDLE with init_done_o=1; on valid_i&ready_o, byte_i is latched and ready_o drops the next cycle.
REQ-027 After a byte is latched with credit=0, POLL_LSR reads adr 5 (we=0, sel 4'b0010) and samples LSR.THRE from wb_dat_i[13] at ack.
REQ-028 If THRE=0, POLL_LSR repeats after one idle cycle; if THRE=1, credit loads BURST and the FSM enters WR_THR.
REQ-029 WR_THR writes adr 0, sel 4'b0001, data {24'b0, byte}; at ack, credit decrements by 1 and the FSM returns to IDLE.
REQ-030 A byte latched with credit>0 goes straight to WR_THR, with no poll.
REQ-031 Credit is a 5-bit counter that saturates at 0 and never wraps.
REQ-032 valid_i is ignored outside IDLE and before init_done_o; upstream holds the byte until ready_o is seen.

Reset
REQ-033 wb_rst_i=1 on any edge, including mid-access: next cycle cyc=stb=we=0, adr=sel=dat=0, ready_o=0, init_done_o=0, credit=0, FSM=CFG_LCR_DLAB.
REQ-034 Configuration restarts from CFG_LCR_DLAB on the first cycle after reset deasserts.
REQ-035 A held or in-flight byte is discarded on reset.

Verification
REQ-036 Reset release, ack 1 cycle after stb -> writes in order: (3, 32'h9B000000, sel 8), (0, 32'h03, sel 1), (1, 32'h0000, sel 2), (3, 32'h1B000000, sel 8); then init_done_o=1 and ready_o=1.
REQ-037 Send 8'h5A, LSR read returns 32'h00002000 -> exactly one LSR read, then a write to adr 0 with data 32'h5A, sel 4'b0001.
REQ-038 LSR returns 32'h0 twice, then 32'h2000 -> three LSR reads, each separated by >=1 idle cycle, then one THR write.
REQ-039 17 back-to-back bytes with THRE=1 -> LSR reads occur only before byte 1 and byte 17; 17 THR writes, in order.
REQ-040 Ack delayed 5 cycles -> adr, dat, sel, we held constant for all 5 cycles; exactly one access completes.
REQ-041 wb_rst_i pulsed while a WR_THR stb is waiting for ack -> cyc=0 the next cycle and configuration replays from CFG_LCR_DLAB.
